death_sequencer: RTL and testbench
==================================

Name: death_sequencer

Overview:
- Consumer of the per-character dead flags produced by the collision stage.
- Runs death, respawn and game-over sequencing for Mario and Luigi, and squish and respawn sequencing for the Gomba.
- Keeps lives and score.
- Outputs feed the sprite/motion blocks: freeze state, vertical death-bounce offset and respawn pulses.

Parameters:
- LIVES_INIT, 3, lives per player after Reset (1..7)
- DEATH_FRAMES, 32, frame ticks spent in DYING
- UP_FRAMES, 12, frame ticks of upward bounce at start of DYING (< DEATH_FRAMES)
- RESPAWN_FRAMES, 60, frame ticks spent in RESPAWN before revival
- SQUISH_FRAMES, 16, frame ticks Gomba shows squished sprite
- GOMBA_RESPAWN_FRAMES, 120, frame ticks Gomba stays GONE
- STOMP_POINTS, 100, score added per Gomba stomp

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_Clk  in  1  frame-rate signal, sampled as data in Clk domain
- mario_dead  in  1  level flag from collision stage
- luigi_dead  in  1  level flag from collision stage
- gomba_dead  in  1  level flag from collision stage
- mario_state  out  2  00 ALIVE, 01 DYING, 10 RESPAWN, 11 OUT
- luigi_state  out  2  same encoding
- mario_y_offset  out  10  two's-complement vertical offset, negative = up
- luigi_y_offset  out  10  same
- mario_respawn  out  1  one-Clk pulse on revival
- luigi_respawn  out  1  one-Clk pulse on revival
- mario_lives  out  3  remaining lives
- luigi_lives  out  3  remaining lives
- gomba_state  out  2  00 ALIVE, 01 SQUISHED, 10 GONE
- gomba_respawn  out  1  one-Clk pulse on Gomba revival
- score  out  16  binary, saturating
- game_over  out  1  high when both players OUT

Behaviour:
- frame_Clk is passed through a 2-flop synchronizer and an edge flop. frame_tick is a 1-Clk pulse on each synchronized rising edge. All frame counts use frame_tick.
- Dead inputs are edge-detected in Clk (registered previous value). Only a 0->1 transition while the target is ALIVE is an event. Levels are otherwise ignored.
- Reset values:
  - states ALIVE; offsets 0; lives = LIVES_INIT; score 0.
  - all pulses 0; game_over 0; frame counters 0; edge/sync flops 0.
  - Reset mid-sequence aborts everything immediately.
- Player FSM (identical for Mario and Luigi, independent):
  - ALIVE -> DYING on dead event. Same Clk: lives decrements (saturates at 0), counter cleared, offset 0.
  - DYING: on each tick, counter++.
    - Ticks 0..UP_FRAMES-1: offset -= 4.
    - Later ticks: offset += 4. Mod-2^10 wrap is permitted; the sprite falls below its origin.
  - Exit on the tick where counter == DEATH_FRAMES-1:
    - lives == 0 -> OUT, offset held.
    - else -> RESPAWN, offset 0, counter cleared.
  - RESPAWN: on the tick where counter == RESPAWN_FRAMES-1 -> ALIVE, respawn pulses for exactly that Clk.
  - OUT is terminal until Reset. Dead events are ignored in every non-ALIVE state.
- Gomba FSM:
  - ALIVE -> SQUISHED on gomba_dead event. Same Clk: score += STOMP_POINTS, saturating at 16'hFFFF.
  - SQUISHED -> GONE after SQUISH_FRAMES ticks.
  - GONE -> ALIVE after GOMBA_RESPAWN_FRAMES ticks, with gomba_respawn pulsing 1 Clk.
- Counting: a dead event and frame_tick in the same Clk: the event wins and the counter starts at 0. That tick is not counted. Every timed state therefore lasts exactly N ticks after entry.
- Simultaneous Mario/Luigi/Gomba events are all processed in the same Clk, with no priority.
- game_over is registered: high the Clk after both player states are OUT, and stays high until Reset.
- All outputs are registered. Event-to-state latency is 1 Clk after the dead input's rising edge is sampled.

Optional Feature:
- Macro: RESPAWN_INVULN_EN.
- Defined:
  - After each player revival, an INVULN_FRAMES counter runs (localparam 90 ticks).
  - Dead events for that player are ignored during those ticks.
  - Extra output mario_blink / luigi_blink (1 bit each) toggles every 4 ticks while invulnerable and is 0 otherwise. Reset value 0.
- Undefined: the blink ports are absent, and a dead event is honoured on the first Clk the player is ALIVE.

Test Plan:
- Reset, mario_dead 0->1 -> next Clk: mario_state=01, mario_lives=2. After 12 ticks mario_y_offset=-48 (10'h3D0). After 32 ticks: state=10, offset 0.
- Continue 60 ticks -> mario_respawn high exactly 1 Clk, state=00. Holding mario_dead high throughout must not retrigger.
- Three Mario deaths -> after third DYING, state=11, lives=0. Further mario_dead edges -> no change. game_over=0 while Luigi is ALIVE.
- Kill Luigi three times with Mario OUT -> game_over=1 the Clk after luigi_state=11. Reset -> all outputs at reset values.
- gomba_dead edge coincident with frame_tick -> gomba_state=01, score=100. Still 01 after 15 ticks; 10 after 16. gomba_respawn pulses after 120 more ticks.
- Assert Reset mid-DYING (tick 5) -> next Clk: state 00, offset 0, lives 3, counters 0. Preload score near 16'hFFF0 via repeated stomps -> score saturates at 16'hFFFF.

Source files
------------

// File: rtl/death_sequencer.sv
// Death/respawn/game-over sequencing for Mario and Luigi, Gomba squish/respawn, lives and score.
// Optional feature: define RESPAWN_INVULN_EN for post-revival invulnerability with blink outputs.

module death_sequencer_player #(
  parameter int LIVES_INIT     = 3,
  parameter int DEATH_FRAMES   = 32,
  parameter int UP_FRAMES      = 12,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       dead,
  output logic [1:0] state,
  output logic [9:0] y_offset,
  output logic       respawn,
  output logic [2:0] lives
`ifdef RESPAWN_INVULN_EN
  ,
  output logic       blink
`endif
);
  localparam logic [1:0] ST_ALIVE   = 2'b00;
  localparam logic [1:0] ST_DYING   = 2'b01;
  localparam logic [1:0] ST_RESPAWN = 2'b10;
  localparam logic [1:0] ST_OUT     = 2'b11;

  logic [1:0] state_r;
  logic [7:0] cnt_r;
  logic [9:0] offset_r;
  logic       respawn_r;
  logic [2:0] lives_r;
  logic       dead_prev_r;
  logic       event_s;
  logic       revive_s;

  assign revive_s = (state_r == ST_RESPAWN) & frame_tick & (cnt_r == 8'(RESPAWN_FRAMES - 1));

`ifdef RESPAWN_INVULN_EN
  localparam int INVULN_FRAMES = 90;
  logic [6:0] inv_cnt_r;
  logic       inv_active_r;
  logic       blink_r;

  assign event_s = dead & ~dead_prev_r & (state_r == ST_ALIVE) & ~inv_active_r;
  assign blink   = blink_r;

  // Invulnerability window after revival; blink toggles every fourth tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      inv_cnt_r    <= 7'd0;
      inv_active_r <= 1'b0;
      blink_r      <= 1'b0;
    end else if (revive_s) begin
      inv_cnt_r    <= 7'd0;
      inv_active_r <= 1'b1;
      blink_r      <= 1'b0;
    end else if (inv_active_r && frame_tick) begin
      if (inv_cnt_r == 7'(INVULN_FRAMES - 1)) begin
        inv_cnt_r    <= 7'd0;
        inv_active_r <= 1'b0;
        blink_r      <= 1'b0;
      end else begin
        inv_cnt_r <= inv_cnt_r + 7'd1;
        if (inv_cnt_r[1:0] == 2'b11) blink_r <= ~blink_r;
      end
    end
  end
`else
  assign event_s = dead & ~dead_prev_r & (state_r == ST_ALIVE);
`endif

  // Player state machine; a dead event outranks a coincident frame tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_ALIVE;
      cnt_r       <= 8'd0;
      offset_r    <= 10'd0;
      respawn_r   <= 1'b0;
      lives_r     <= 3'(LIVES_INIT);
      dead_prev_r <= 1'b0;
    end else begin
      dead_prev_r <= dead;
      respawn_r   <= 1'b0;
      case (state_r)
        ST_ALIVE: begin
          if (event_s) begin
            state_r  <= ST_DYING;
            lives_r  <= (lives_r == 3'd0) ? 3'd0 : lives_r - 3'd1;
            cnt_r    <= 8'd0;
            offset_r <= 10'd0;
          end
        end
        ST_DYING: begin
          if (frame_tick) begin
            if (cnt_r < 8'(UP_FRAMES)) offset_r <= offset_r - 10'd4;
            else                       offset_r <= offset_r + 10'd4;
            if (cnt_r == 8'(DEATH_FRAMES - 1)) begin
              cnt_r <= 8'd0;
              if (lives_r == 3'd0) begin
                state_r <= ST_OUT;
              end else begin
                state_r  <= ST_RESPAWN;
                offset_r <= 10'd0;
              end
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
        end
        ST_RESPAWN: begin
          if (revive_s) begin
            state_r   <= ST_ALIVE;
            respawn_r <= 1'b1;
            cnt_r     <= 8'd0;
          end else if (frame_tick) begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_OUT: state_r <= ST_OUT;
        default: state_r <= ST_ALIVE;
      endcase
    end
  end

  assign state    = state_r;
  assign y_offset = offset_r;
  assign respawn  = respawn_r;
  assign lives    = lives_r;
endmodule

module death_sequencer #(
  parameter int LIVES_INIT           = 3,
  parameter int DEATH_FRAMES         = 32,
  parameter int UP_FRAMES            = 12,
  parameter int RESPAWN_FRAMES       = 60,
  parameter int SQUISH_FRAMES        = 16,
  parameter int GOMBA_RESPAWN_FRAMES = 120,
  parameter int STOMP_POINTS         = 100
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_Clk,
  input  logic        mario_dead,
  input  logic        luigi_dead,
  input  logic        gomba_dead,
  output logic [1:0]  mario_state,
  output logic [1:0]  luigi_state,
  output logic [9:0]  mario_y_offset,
  output logic [9:0]  luigi_y_offset,
  output logic        mario_respawn,
  output logic        luigi_respawn,
  output logic [2:0]  mario_lives,
  output logic [2:0]  luigi_lives,
  output logic [1:0]  gomba_state,
  output logic        gomba_respawn,
  output logic [15:0] score,
  output logic        game_over
`ifdef RESPAWN_INVULN_EN
  ,
  output logic        mario_blink,
  output logic        luigi_blink
`endif
);
  localparam logic [1:0] G_ALIVE    = 2'b00;
  localparam logic [1:0] G_SQUISHED = 2'b01;
  localparam logic [1:0] G_GONE     = 2'b10;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic       sync1_r, sync2_r, frame_prev_r;
  logic       frame_tick_s;
  logic [1:0] g_state_r;
  logic [7:0] g_cnt_r;
  logic       g_respawn_r;
  logic       g_dead_prev_r;
  logic [15:0] score_r;
  logic       game_over_r;

  assign frame_tick_s = sync2_r & ~frame_prev_r;

  // frame_Clk synchronizer and rising-edge detector.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      frame_prev_r <= 1'b0;
    end else begin
      sync1_r      <= frame_Clk;
      sync2_r      <= sync1_r;
      frame_prev_r <= sync2_r;
    end
  end

  death_sequencer_player #(
    .LIVES_INIT(LIVES_INIT), .DEATH_FRAMES(DEATH_FRAMES),
    .UP_FRAMES(UP_FRAMES), .RESPAWN_FRAMES(RESPAWN_FRAMES)
  ) u_mario (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick_s), .dead(mario_dead),
    .state(mario_state), .y_offset(mario_y_offset), .respawn(mario_respawn), .lives(mario_lives)
`ifdef RESPAWN_INVULN_EN
    , .blink(mario_blink)
`endif
  );

  death_sequencer_player #(
    .LIVES_INIT(LIVES_INIT), .DEATH_FRAMES(DEATH_FRAMES),
    .UP_FRAMES(UP_FRAMES), .RESPAWN_FRAMES(RESPAWN_FRAMES)
  ) u_luigi (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick_s), .dead(luigi_dead),
    .state(luigi_state), .y_offset(luigi_y_offset), .respawn(luigi_respawn), .lives(luigi_lives)
`ifdef RESPAWN_INVULN_EN
    , .blink(luigi_blink)
`endif
  );

  // Gomba squish/respawn sequencing and score keeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      g_state_r     <= G_ALIVE;
      g_cnt_r       <= 8'd0;
      g_respawn_r   <= 1'b0;
      g_dead_prev_r <= 1'b0;
      score_r       <= 16'd0;
    end else begin
      g_dead_prev_r <= gomba_dead;
      g_respawn_r   <= 1'b0;
      case (g_state_r)
        G_ALIVE: begin
          if (gomba_dead && !g_dead_prev_r) begin
            g_state_r <= G_SQUISHED;
            g_cnt_r   <= 8'd0;
            score_r   <= sat_add16(score_r, 16'(STOMP_POINTS));
          end
        end
        G_SQUISHED: begin
          if (frame_tick_s) begin
            if (g_cnt_r == 8'(SQUISH_FRAMES - 1)) begin
              g_state_r <= G_GONE;
              g_cnt_r   <= 8'd0;
            end else begin
              g_cnt_r <= g_cnt_r + 8'd1;
            end
          end
        end
        G_GONE: begin
          if (frame_tick_s) begin
            if (g_cnt_r == 8'(GOMBA_RESPAWN_FRAMES - 1)) begin
              g_state_r   <= G_ALIVE;
              g_cnt_r     <= 8'd0;
              g_respawn_r <= 1'b1;
            end else begin
              g_cnt_r <= g_cnt_r + 8'd1;
            end
          end
        end
        default: g_state_r <= G_ALIVE;
      endcase
    end
  end

  // Sticky game-over once both players are out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      game_over_r <= 1'b0;
    end else begin
      game_over_r <= game_over_r | ((mario_state == 2'b11) & (luigi_state == 2'b11));
    end
  end

  assign gomba_state   = g_state_r;
  assign gomba_respawn = g_respawn_r;
  assign score         = score_r;
  assign game_over     = game_over_r;
endmodule

// File: tb/tb_death_sequencer.sv
// Directed self-checking bench for death_sequencer (default build, RESPAWN_INVULN_EN undefined).
module tb_death_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_Clk = 1'b0;
  logic mario_dead = 1'b0, luigi_dead = 1'b0, gomba_dead = 1'b0, gomba_dead2 = 1'b0;
  logic [1:0] mario_state, luigi_state, gomba_state;
  logic [9:0] mario_y_offset, luigi_y_offset;
  logic mario_respawn, luigi_respawn, gomba_respawn, game_over;
  logic [2:0] mario_lives, luigi_lives;
  logic [15:0] score;
  logic [1:0] s_mstate, s_lstate, s_gstate;
  logic [9:0] s_moff, s_loff;
  logic s_mresp, s_lresp, s_gresp, s_gover;
  logic [2:0] s_mlives, s_llives;
  logic [15:0] s_score;
`ifdef RESPAWN_INVULN_EN
  logic mario_blink, luigi_blink, s_mblink, s_lblink;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int mario_resp_cnt = 0;
  int gomba_resp_cnt = 0;

  death_sequencer dut (
    .Clk(Clk), .Reset(Reset), .frame_Clk(frame_Clk),
    .mario_dead(mario_dead), .luigi_dead(luigi_dead), .gomba_dead(gomba_dead),
    .mario_state(mario_state), .luigi_state(luigi_state),
    .mario_y_offset(mario_y_offset), .luigi_y_offset(luigi_y_offset),
    .mario_respawn(mario_respawn), .luigi_respawn(luigi_respawn),
    .mario_lives(mario_lives), .luigi_lives(luigi_lives),
    .gomba_state(gomba_state), .gomba_respawn(gomba_respawn),
    .score(score), .game_over(game_over)
`ifdef RESPAWN_INVULN_EN
    , .mario_blink(mario_blink), .luigi_blink(luigi_blink)
`endif
  );

  // Short Gomba timings so the score can be driven to saturation quickly.
  death_sequencer #(.SQUISH_FRAMES(1), .GOMBA_RESPAWN_FRAMES(1)) u_sat (
    .Clk(Clk), .Reset(Reset), .frame_Clk(frame_Clk),
    .mario_dead(1'b0), .luigi_dead(1'b0), .gomba_dead(gomba_dead2),
    .mario_state(s_mstate), .luigi_state(s_lstate),
    .mario_y_offset(s_moff), .luigi_y_offset(s_loff),
    .mario_respawn(s_mresp), .luigi_respawn(s_lresp),
    .mario_lives(s_mlives), .luigi_lives(s_llives),
    .gomba_state(s_gstate), .gomba_respawn(s_gresp),
    .score(s_score), .game_over(s_gover)
`ifdef RESPAWN_INVULN_EN
    , .mario_blink(s_mblink), .luigi_blink(s_lblink)
`endif
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (mario_respawn) mario_resp_cnt++;
    if (gomba_respawn) gomba_resp_cnt++;
  end

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_Clk = 1'b0;
    mario_dead = 1'b0; luigi_dead = 1'b0; gomba_dead = 1'b0; gomba_dead2 = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_Clk = 1'b1;
      repeat (2) @(negedge Clk);
      frame_Clk = 1'b0;
      repeat (2) @(negedge Clk);
    end
  endtask

  task automatic pulse(input int sel);
    if (sel == 0) mario_dead = 1'b1; else luigi_dead = 1'b1;
    @(negedge Clk);
    mario_dead = 1'b0; luigi_dead = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if ({mario_state, luigi_state, gomba_state} !== 6'd0) begin n_fail++; $display("FAIL reset_states: got %b expected 000000", {mario_state, luigi_state, gomba_state}); end
    n_checks++; if ({mario_y_offset, luigi_y_offset} !== 20'd0) begin n_fail++; $display("FAIL reset_offsets: got %h expected 0", {mario_y_offset, luigi_y_offset}); end
    n_checks++; if ({mario_lives, luigi_lives} !== 6'o33) begin n_fail++; $display("FAIL reset_lives: got %o expected 33", {mario_lives, luigi_lives}); end
    n_checks++; if ({score, game_over, mario_respawn, luigi_respawn, gomba_respawn} !== 20'd0) begin n_fail++; $display("FAIL reset_score_flags: got %h expected 0", {score, game_over, mario_respawn, luigi_respawn, gomba_respawn}); end
  endtask

  task automatic test_mario_death();
    mario_dead = 1'b1;
    @(negedge Clk);
    n_checks++; if (mario_state !== 2'b01) begin n_fail++; $display("FAIL mario_dying_state: got %b expected 01", mario_state); end
    n_checks++; if (mario_lives !== 3'd2) begin n_fail++; $display("FAIL mario_lives_dec: got %0d expected 2", mario_lives); end
    ticks(12);
    n_checks++; if (mario_y_offset !== 10'h3D0) begin n_fail++; $display("FAIL mario_bounce_top: got %h expected 3d0", mario_y_offset); end
    n_checks++; if (mario_state !== 2'b01) begin n_fail++; $display("FAIL mario_still_dying: got %b expected 01", mario_state); end
    ticks(20);
    n_checks++; if (mario_state !== 2'b10) begin n_fail++; $display("FAIL mario_to_respawn: got %b expected 10", mario_state); end
    n_checks++; if (mario_y_offset !== 10'd0) begin n_fail++; $display("FAIL mario_respawn_offset: got %h expected 0", mario_y_offset); end
  endtask

  task automatic test_respawn_hold();
    int base;
    base = mario_resp_cnt;
    ticks(59);
    n_checks++; if (mario_state !== 2'b10) begin n_fail++; $display("FAIL mario_respawn_59: got %b expected 10", mario_state); end
    n_checks++; if (mario_resp_cnt !== base) begin n_fail++; $display("FAIL mario_early_pulse: got %0d expected %0d", mario_resp_cnt, base); end
    ticks(1);
    n_checks++; if (mario_state !== 2'b00) begin n_fail++; $display("FAIL mario_revived: got %b expected 00", mario_state); end
    n_checks++; if (mario_resp_cnt !== base + 1) begin n_fail++; $display("FAIL mario_pulse_width: got %0d expected %0d", mario_resp_cnt, base + 1); end
    repeat (4) @(negedge Clk);
    n_checks++; if (mario_state !== 2'b00) begin n_fail++; $display("FAIL mario_level_retrigger: got %b expected 00", mario_state); end
    mario_dead = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_mario_out();
    pulse(0); ticks(32); ticks(60);
    n_checks++; if ({mario_state, mario_lives} !== 5'b00_001) begin n_fail++; $display("FAIL mario_second_life: got %b expected 00001", {mario_state, mario_lives}); end
    pulse(0); ticks(32);
    n_checks++; if ({mario_state, mario_lives} !== 5'b11_000) begin n_fail++; $display("FAIL mario_out: got %b expected 11000", {mario_state, mario_lives}); end
    pulse(0); ticks(2);
    n_checks++; if ({mario_state, mario_lives} !== 5'b11_000) begin n_fail++; $display("FAIL mario_out_ignores: got %b expected 11000", {mario_state, mario_lives}); end
    n_checks++; if ({game_over, luigi_state} !== 3'b000) begin n_fail++; $display("FAIL no_game_over_yet: got %b expected 000", {game_over, luigi_state}); end
  endtask

  task automatic test_game_over();
    bit found;
    for (int k = 0; k < 2; k++) begin
      pulse(1); ticks(32); ticks(60);
    end
    pulse(1); ticks(31);
    n_checks++; if ({luigi_state, luigi_lives, game_over} !== 6'b01_000_0) begin n_fail++; $display("FAIL luigi_last_dying: got %b expected 010000", {luigi_state, luigi_lives, game_over}); end
    frame_Clk = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge Clk);
      if (luigi_state == 2'b11) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL luigi_out_timeout: got state %b expected 11", luigi_state); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL game_over_early: got %b expected 0", game_over); end
    @(negedge Clk);
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL game_over_set: got %b expected 1", game_over); end
    frame_Clk = 1'b0;
    repeat (2) @(negedge Clk);
    apply_reset();
    n_checks++; if ({mario_state, luigi_state, mario_lives, luigi_lives, game_over} !== 11'b00_00_011_011_0) begin n_fail++; $display("FAIL reset_after_game_over: got %b expected 00000110110", {mario_state, luigi_state, mario_lives, luigi_lives, game_over}); end
  endtask

  task automatic test_gomba();
    int base;
    base = gomba_resp_cnt;
    frame_Clk = 1'b1;
    repeat (2) @(negedge Clk);
    gomba_dead = 1'b1; frame_Clk = 1'b0;
    @(negedge Clk);
    n_checks++; if ({gomba_state, score} !== {2'b01, 16'd100}) begin n_fail++; $display("FAIL gomba_stomp: got %b/%0d expected 01/100", gomba_state, score); end
    gomba_dead = 1'b0;
    repeat (2) @(negedge Clk);
    ticks(15);
    n_checks++; if (gomba_state !== 2'b01) begin n_fail++; $display("FAIL gomba_squish_15: got %b expected 01", gomba_state); end
    ticks(1);
    n_checks++; if (gomba_state !== 2'b10) begin n_fail++; $display("FAIL gomba_gone_16: got %b expected 10", gomba_state); end
    ticks(119);
    n_checks++; if ({gomba_state, gomba_resp_cnt[3:0]} !== {2'b10, 4'(base)}) begin n_fail++; $display("FAIL gomba_gone_119: got %b/%0d expected 10/%0d", gomba_state, gomba_resp_cnt, base); end
    ticks(1);
    n_checks++; if ({gomba_state, gomba_resp_cnt[3:0]} !== {2'b00, 4'(base + 1)}) begin n_fail++; $display("FAIL gomba_revive: got %b/%0d expected 00/%0d", gomba_state, gomba_resp_cnt, base + 1); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pulse(0); ticks(5);
    n_checks++; if (mario_y_offset !== 10'h3EC) begin n_fail++; $display("FAIL mario_tick5_offset: got %h expected 3ec", mario_y_offset); end
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++; if ({mario_state, mario_y_offset, mario_lives} !== {2'b00, 10'd0, 3'd3}) begin n_fail++; $display("FAIL reset_mid_dying: got %b/%h/%0d expected 00/000/3", mario_state, mario_y_offset, mario_lives); end
    Reset = 1'b0;
    pulse(0); ticks(12);
    n_checks++; if (mario_y_offset !== 10'h3D0) begin n_fail++; $display("FAIL post_reset_count: got %h expected 3d0", mario_y_offset); end
    apply_reset();
  endtask

  task automatic stomp2();
    gomba_dead2 = 1'b1;
    @(negedge Clk);
    gomba_dead2 = 1'b0;
    ticks(2);
  endtask

  task automatic test_score_saturate();
    for (int i = 0; i < 655; i++) stomp2();
    n_checks++; if (s_score !== 16'd65500) begin n_fail++; $display("FAIL score_655: got %h expected ffdc", s_score); end
    stomp2();
    n_checks++; if (s_score !== 16'hFFFF) begin n_fail++; $display("FAIL score_saturate: got %h expected ffff", s_score); end
    stomp2();
    n_checks++; if ({s_score, s_gstate} !== {16'hFFFF, 2'b00}) begin n_fail++; $display("FAIL score_stays_sat: got %h/%b expected ffff/00", s_score, s_gstate); end
  endtask

  initial begin
    test_reset();
    test_mario_death();
    test_respawn_hold();
    test_mario_out();
    test_game_over();
    test_gomba();
    test_reset_mid();
    test_score_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
